// File: rtl/mips_mc_ctrl_pkg.sv
// mips_defs: shared definitions for the multi-cycle MIPS controller.
// Holds the opcode/funct constants, the FSM state and instruction-class
// enums, the datapath select codes, and the two pure functions that give
// the FSM its transitions and its per-state control word.
package mips_defs;

    // Instruction fields
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    // Next-PC source
    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_REG = 2'd3;

    // ALU B operand source
    localparam logic [1:0] B_RT   = 2'd0;
    localparam logic [1:0] B_SEXT = 2'd1;
    localparam logic [1:0] B_ZEXT = 2'd2;

    // Destination register select
    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    // Register-file write data source
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MDR = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXE_R   = 4'd2,
        ST_EXE_I   = 4'd3,
        ST_ALU_WB  = 4'd4,
        ST_MEM_ADR = 4'd5,
        ST_MEM_RD  = 4'd6,
        ST_MEM_WB  = 4'd7,
        ST_MEM_WR  = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CL_R_ALU,
        CL_I_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_JAL,
        CL_JR,
        CL_ILLEGAL
    } instr_class_t;

    // Control word held in the output register. br_cond marks the BRANCH
    // state, where the PC write is qualified by the live zero flag.
    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       rf_we;
        logic       dm_we;
        logic       br_cond;
        logic       instr_done;
        logic [1:0] pc_sel;
        logic [2:0] alu_op;
        logic [1:0] alu_b_sel;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
    } ctrl_t;

    function automatic state_t next_state(input state_t st, input instr_class_t cls);
        state_t nxt;
        nxt = ST_FETCH;
        case (st)
            ST_FETCH:   nxt = ST_DECODE;
            ST_DECODE: begin
                case (cls)
                    CL_R_ALU:              nxt = ST_EXE_R;
                    CL_I_ALU:              nxt = ST_EXE_I;
                    CL_LOAD, CL_STORE:     nxt = ST_MEM_ADR;
                    CL_BRANCH:             nxt = ST_BRANCH;
                    CL_JUMP, CL_JAL, CL_JR: nxt = ST_JUMP;
                    default:               nxt = ST_FETCH;
                endcase
            end
            ST_EXE_R, ST_EXE_I: nxt = ST_ALU_WB;
            ST_MEM_ADR: nxt = (cls == CL_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  nxt = ST_MEM_WB;
            default:    nxt = ST_FETCH;
        endcase
        return nxt;
    endfunction

    // Control word for a state. Called with the state being entered so the
    // outputs come straight out of a register; the IR class is stable from
    // DECODE onward, which covers every state that looks at it.
    function automatic ctrl_t state_outputs(input state_t st, input instr_class_t cls,
                                            input logic [2:0] alu_fn);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.ir_we  = 1'b1;
                c.pc_we  = 1'b1;
                c.pc_sel = PC_SEQ;
            end
            ST_EXE_R, ST_EXE_I: begin
                c.alu_b_sel = (st == ST_EXE_R) ? B_RT : B_ZEXT;
                c.alu_op    = alu_fn;
            end
            ST_ALU_WB: begin
                c.rf_we      = 1'b1;
                c.wd_sel     = WD_ALU;
                c.reg_dst    = (cls == CL_R_ALU) ? DST_RD : DST_RT;
                c.instr_done = 1'b1;
            end
            ST_MEM_ADR: begin
                c.alu_b_sel = B_SEXT;
                c.alu_op    = ALU_ADD;
            end
            ST_MEM_WB: begin
                c.rf_we      = 1'b1;
                c.wd_sel     = WD_MDR;
                c.reg_dst    = DST_RT;
                c.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                c.dm_we      = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_op     = ALU_SUB;
                c.alu_b_sel  = B_RT;
                c.pc_sel     = PC_BR;
                c.br_cond    = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_JUMP: begin
                c.pc_we      = 1'b1;
                c.pc_sel     = (cls == CL_JR) ? PC_REG : PC_JMP;
                c.instr_done = 1'b1;
                if (cls == CL_JAL) begin
                    c.rf_we   = 1'b1;
                    c.reg_dst = DST_RA;
                    c.wd_sel  = WD_PC;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// mips_mc_decode: combinational instruction classifier.
// Ports:
//   opcode  in  IR[31:26]
//   funct   in  IR[5:0]
//   cls     out instruction class consumed by the FSM
//   alu_fn  out ALU operation for the execute step of ALU/branch classes
// Anything not recognised, including the all-zero nop (sll), is ILLEGAL,
// which the FSM retires without writing anything.
module mips_mc_decode
    import mips_defs::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic [2:0]   alu_fn
);

    always_comb begin
        cls    = CL_ILLEGAL;
        alu_fn = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin cls = CL_R_ALU; alu_fn = ALU_ADD; end
                    FN_SUBU: begin cls = CL_R_ALU; alu_fn = ALU_SUB; end
                    FN_JR:   cls = CL_JR;
                    default: cls = CL_ILLEGAL;
                endcase
            end
            OP_ORI:  begin cls = CL_I_ALU; alu_fn = ALU_OR;  end
            OP_LUI:  begin cls = CL_I_ALU; alu_fn = ALU_LUI; end
            OP_LW:   cls = CL_LOAD;
            OP_SW:   cls = CL_STORE;
            OP_BEQ:  begin cls = CL_BRANCH; alu_fn = ALU_SUB; end
            OP_J:    cls = CL_JUMP;
            OP_JAL:  cls = CL_JAL;
            default: cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle control FSM for the MIPS datapath.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   opcode, funct, zero IR fields and ALU equality flag
//   pc_we/ir_we/rf_we/dm_we  architectural write enables
//   pc_sel, alu_op, alu_b_sel, reg_dst, wd_sel  datapath selects
//   instr_done          pulse in the last cycle of every instruction
//   state               current state encoding (debug)
module mips_mc_ctrl
    import mips_defs::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_we,
    output logic               ir_we,
    output logic               rf_we,
    output logic               dm_we,
    output logic [1:0]         pc_sel,
    output logic [2:0]         alu_op,
    output logic [1:0]         alu_b_sel,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wd_sel,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    state_t       state_q;
    ctrl_t        ctl_q;
    instr_class_t cls;
    logic [2:0]   alu_fn;
    logic         decode_illegal;

    mips_mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls),
        .alu_fn (alu_fn)
    );

    // The control word is computed for the state being entered, so every
    // output leaves a flop. Reset lands in FETCH with FETCH's control word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ctl_q   <= state_outputs(ST_FETCH, CL_ILLEGAL, ALU_ADD);
        end else begin
            state_q <= next_state(state_q, cls);
            ctl_q   <= state_outputs(next_state(state_q, cls), cls, alu_fn);
        end
    end

    // The IR is loaded on the same edge that enters DECODE, so an illegal
    // instruction can only be recognised once DECODE is live; its done pulse
    // is therefore decoded from the state register and the current class.
    assign decode_illegal = (state_q == ST_DECODE) && (cls == CL_ILLEGAL);

    // Write enables and done are gated by reset so nothing is written while
    // an abandoned instruction is being flushed.
    assign pc_we      = ~reset & (ctl_q.pc_we | (ctl_q.br_cond & zero));
    assign ir_we      = ~reset & ctl_q.ir_we;
    assign rf_we      = ~reset & ctl_q.rf_we;
    assign dm_we      = ~reset & ctl_q.dm_we;
    assign instr_done = ~reset & (ctl_q.instr_done | decode_illegal);

    assign pc_sel    = ctl_q.pc_sel;
    assign alu_op    = ctl_q.alu_op;
    assign alu_b_sel = ctl_q.alu_b_sel;
    assign reg_dst   = ctl_q.reg_dst;
    assign wd_sel    = ctl_q.wd_sel;
    assign state     = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: randomized self-checking bench for mips_mc_ctrl.
// The reference model describes each instruction only by its latency and by
// what it does in its first, execute and last cycles.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_we, ir_we, rf_we, dm_we, instr_done;
    logic [1:0] pc_sel, alu_b_sel, reg_dst, wd_sel;
    logic [2:0] alu_op;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
    localparam int K_BEQ  = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;

    mips_mc_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .rf_we      (rf_we),
        .dm_we      (dm_we),
        .pc_sel     (pc_sel),
        .alu_op     (alu_op),
        .alu_b_sel  (alu_b_sel),
        .reg_dst    (reg_dst),
        .wd_sel     (wd_sel),
        .instr_done (instr_done),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic string kname(input int k);
        case (k)
            K_ADDU: return "addu";
            K_SUBU: return "subu";
            K_ORI:  return "ori";
            K_LUI:  return "lui";
            K_LW:   return "lw";
            K_SW:   return "sw";
            K_BEQ:  return "beq";
            K_J:    return "j";
            K_JAL:  return "jal";
            K_JR:   return "jr";
            default: return "illegal";
        endcase
    endfunction

    // Cycles from FETCH to the done cycle inclusive.
    function automatic int latency(input int k);
        case (k)
            K_BEQ, K_J, K_JAL, K_JR: return 3;
            K_LW:                    return 5;
            K_ILL:                   return 2;
            default:                 return 4;
        endcase
    endfunction

    // Register-file destination on the done cycle, -1 when nothing is written.
    function automatic int rfDst(input int k);
        case (k)
            K_ADDU, K_SUBU:     return 1;
            K_ORI, K_LUI, K_LW: return 0;
            K_JAL:              return 2;
            default:            return -1;
        endcase
    endfunction

    function automatic int wdSrc(input int k);
        case (k)
            K_LW:    return 1;
            K_JAL:   return 2;
            default: return 0;
        endcase
    endfunction

    // Next-PC select on the done cycle, -1 when the instruction has no PC change.
    function automatic int pcSrc(input int k);
        case (k)
            K_BEQ:      return 1;
            K_J, K_JAL: return 2;
            K_JR:       return 3;
            default:    return -1;
        endcase
    endfunction

    // ALU operation and B source in the third cycle, -1 when the ALU is unused.
    function automatic int aluFn(input int k);
        case (k)
            K_ADDU, K_LW, K_SW: return 0;
            K_SUBU, K_BEQ:      return 1;
            K_ORI:              return 2;
            K_LUI:              return 3;
            default:            return -1;
        endcase
    endfunction

    function automatic int bSrc(input int k);
        case (k)
            K_ORI, K_LUI: return 2;
            K_LW, K_SW:   return 1;
            default:      return 0;
        endcase
    endfunction

    // Runs one instruction from its FETCH cycle to its done cycle. Called
    // just after a rising edge; the IR fields change after the FETCH edge.
    task automatic applyStimulus(input int k, input logic [5:0] op, input logic [5:0] fn,
                                 input int zmode);
        int L;
        L = latency(k);
        for (int c = 1; c <= L; c++) begin
            logic [4:0] expEn;
            logic       z;
            string      tg;
            if (c == 2) begin
                opcode = op;
                funct  = fn;
            end
            z    = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            zero = z;
            @(negedge clk);
            tg = $sformatf("%s c%0d", kname(k), c);
            expEn = 5'b0;
            if (c == 1) expEn = 5'b11000;
            if (c == L) begin
                expEn[0] = 1'b1;
                if (rfDst(k) >= 0) expEn[2] = 1'b1;
                if (k == K_SW) expEn[1] = 1'b1;
                if (k == K_J || k == K_JAL || k == K_JR || (k == K_BEQ && z)) expEn[3] = 1'b1;
            end
            checkOutput({tg, " en{ir,pc,rf,dm,done}"},
                        32'({ir_we, pc_we, rf_we, dm_we, instr_done}), 32'(expEn));
            if (c == 1) checkOutput({tg, " pc_sel"}, 32'(pc_sel), 32'd0);
            if (c == L && pcSrc(k) >= 0) checkOutput({tg, " pc_sel"}, 32'(pc_sel), 32'(pcSrc(k)));
            if (c == L && rfDst(k) >= 0) begin
                checkOutput({tg, " reg_dst"}, 32'(reg_dst), 32'(rfDst(k)));
                checkOutput({tg, " wd_sel"}, 32'(wd_sel), 32'(wdSrc(k)));
            end
            if (c == 3 && aluFn(k) >= 0) begin
                checkOutput({tg, " alu_op"}, 32'(alu_op), 32'(aluFn(k)));
                checkOutput({tg, " alu_b_sel"}, 32'(alu_b_sel), 32'(bSrc(k)));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runKind(input int k, input int zmode);
        logic [5:0] op;
        logic [5:0] fn;
        int         pick;
        fn = 6'($urandom_range(0, 63));
        case (k)
            K_ADDU: begin op = 6'h00; fn = 6'h21; end
            K_SUBU: begin op = 6'h00; fn = 6'h23; end
            K_ORI:  op = 6'h0D;
            K_LUI:  op = 6'h0F;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2B;
            K_BEQ:  op = 6'h04;
            K_J:    op = 6'h02;
            K_JAL:  op = 6'h03;
            K_JR:   begin op = 6'h00; fn = 6'h08; end
            default: begin
                pick = $urandom_range(0, 3);
                case (pick)
                    0:       op = 6'h3F;
                    1:       begin op = 6'h00; fn = 6'h00; end
                    2:       begin op = 6'h00; fn = 6'h20; end
                    default: op = 6'h08;
                endcase
            end
        endcase
        applyStimulus(k, op, fn, zmode);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset  = 1'b1;
        opcode = 6'h3F;
        funct  = 6'h00;
        zero   = 1'b0;

        repeat (5) begin
            @(negedge clk);
            checkOutput("reset en", 32'({pc_we, ir_we, rf_we, dm_we, instr_done}), 32'd0);
            checkOutput("reset state", 32'(state), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        runKind(K_ADDU, 2);
        runKind(K_LW, 2);
        runKind(K_SW, 2);
        runKind(K_BEQ, 1);
        runKind(K_BEQ, 0);
        runKind(K_JAL, 2);
        runKind(K_JR, 2);
        applyStimulus(K_ILL, 6'h3F, 6'h00, 2);
        applyStimulus(K_ILL, 6'h00, 6'h00, 2);
        runKind(K_J, 2);
        runKind(K_SUBU, 2);
        runKind(K_ORI, 2);
        runKind(K_LUI, 2);

        // Abandon a load while it is reading memory: no writeback may follow.
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin
                opcode = 6'h23;
                funct  = 6'h00;
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        checkOutput("midreset state", 32'(state), 32'd0);
        checkOutput("midreset en", 32'({pc_we, ir_we, rf_we, dm_we, instr_done}), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("midreset held en", 32'({pc_we, ir_we, rf_we, dm_we, instr_done}), 32'd0);
        checkOutput("midreset held state", 32'(state), 32'd0);
        reset = 1'b0;

        repeat (200) runKind($urandom_range(0, 10), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
